// File: rtl/aes_pkg.sv
// Shared AES tables and GF(2^8) helpers for the iterative cipher cores.
// Holds the forward S-box, column-mix multipliers, FSM states and key sizes.
package aes_pkg;

    localparam int AES128_NK = 4;
    localparam int AES128_NR = 10;
    localparam int AES192_NK = 6;
    localparam int AES192_NR = 12;
    localparam int AES256_NK = 8;
    localparam int AES256_NR = 14;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Generic multiply; the inverse column mix uses 9/11/13/14.
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return gf_mul(b, 8'h09);
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return gf_mul(b, 8'h0b);
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return gf_mul(b, 8'h0d);
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return gf_mul(b, 8'h0e);
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational forward AES round.
// The last round skips the column mix.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [0:127] state,
    input  logic [0:127] roundKey,
    input  logic         last,
    output logic [0:127] result
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sb[k] = sbox(state[8*k +: 8]);
        end
    end

    // Byte k is row k%4, column k/4; row r rotates left by r.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = mul2(sr[4*c]) ^ mul3(sr[4*c+1])
                      ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ mul2(sr[4*c+1])
                      ^ mul3(sr[4*c+2]) ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1]
                      ^ mul2(sr[4*c+2]) ^ mul3(sr[4*c+3]);
            mc[4*c+3] = mul3(sr[4*c]) ^ sr[4*c+1]
                      ^ sr[4*c+2] ^ mul2(sr[4*c+3]);
        end
    end

    always_comb begin
        result = '0;
        for (int k = 0; k < 16; k++) begin
            result[8*k +: 8] = (last ? sr[k] : mc[k])
                             ^ roundKey[8*k +: 8];
        end
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor: one round per clock, external key schedule.
// Valid/ready on both sides; result held in DONE until drained.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:127]           plaintext,
    input  logic [0:128*(nr+1)-1]  keySchedule,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:127]           ciphertext,
    output logic                   busy
);

    if (nr != nk + 6) begin : g_bad_cfg
        $error("aes_encrypt_iter: nr must equal nk+6");
    end

    localparam logic [3:0] LAST_RND = 4'(nr - 1);
    localparam logic [3:0] MAX_RND  = 4'(nr);

    aes_state_e   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [0:127] blk_q, blk_d;
    logic [0:127] rk;
    logic [0:127] round_out;

    always_comb begin
        rk = keySchedule[0 +: 128];
        for (int r = 1; r <= nr; r++) begin
            if (rnd_q == 4'(r)) rk = keySchedule[128*r +: 128];
        end
    end

    aes_enc_round u_round (
        .state    (blk_q),
        .roundKey (rk),
        .last     (state_q == FINAL),
        .result   (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        blk_d     = blk_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    blk_d   = plaintext ^ keySchedule[0 +: 128];
                    rnd_d   = 4'd1;
                    state_d = (nr == 1) ? FINAL : ROUND;
                end
            end
            ROUND: begin
                busy  = 1'b1;
                blk_d = round_out;
                rnd_d = (rnd_q == MAX_RND) ? rnd_q : rnd_q + 4'd1;
                if (rnd_q == LAST_RND) state_d = FINAL;
            end
            FINAL: begin
                busy    = 1'b1;
                blk_d   = round_out;
                state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    rnd_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ciphertext = blk_q;

endmodule
